// File: rtl/jam_cost_loader_pkg.sv
// jam_cost_loader_pkg: cost-table constants and loader state type shared with the search stage
package jam_cost_loader_pkg;
   localparam int N_W         = 8;
   localparam int N_J         = 8;
   localparam int COST_W      = 7;
   localparam int LB_W        = 10;
   localparam int TABLE_BEATS = N_W * N_J;
   typedef enum logic {LOAD, FULL} state_t;
endpackage

// File: rtl/jam_cost_loader_row_min_acc.sv
// row_min_acc: per-worker running minimum and sum of completed row minima (LowerBound)
module row_min_acc #(
   parameter int N_W    = jam_cost_loader_pkg::N_W,
   parameter int COST_W = jam_cost_loader_pkg::COST_W,
   parameter int LB_W   = jam_cost_loader_pkg::LB_W
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   clear,
   input  logic                   wr,
   input  logic [$clog2(N_W)-1:0] row,
   input  logic                   last,
   input  logic [COST_W-1:0]      cost,
   output logic [LB_W-1:0]        lower_bound
);
   logic [COST_W-1:0] rowmin [N_W];
   logic [COST_W-1:0] cur_min;
   // includes the beat being written, so the row's final minimum is ready on its last beat
   assign cur_min = (cost < rowmin[row]) ? cost : rowmin[row];
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < N_W; i++) rowmin[i] <= '1;
         lower_bound <= '0;
      end else if (clear) begin
         for (int i = 0; i < N_W; i++) rowmin[i] <= '1;
         lower_bound <= '0;
      end else if (wr) begin
         rowmin[row] <= cur_min;
         if (last) lower_bound <= lower_bound + LB_W'(cur_min);
      end
   end
endmodule

// File: rtl/jam_cost_loader.sv
// jam_cost_loader: streams the worker/job cost matrix into a register file and serves W/J lookups
module jam_cost_loader import jam_cost_loader_pkg::*; #(
   parameter int N_W    = jam_cost_loader_pkg::N_W,
   parameter int N_J    = jam_cost_loader_pkg::N_J,
   parameter int COST_W = jam_cost_loader_pkg::COST_W,
   parameter int LB_W   = jam_cost_loader_pkg::LB_W
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [COST_W-1:0]      in_cost,
   input  logic                   clear,
   input  logic [$clog2(N_W)-1:0] W,
   input  logic [$clog2(N_J)-1:0] J,
   output logic [COST_W-1:0]      Cost,
   output logic                   Loaded,
   output logic [LB_W-1:0]        LowerBound
);
   localparam int WW    = $clog2(N_W);
   localparam int JW    = $clog2(N_J);
   localparam int CW    = WW + JW;
   localparam int BEATS = N_W * N_J;
   state_t            state;
   logic [CW-1:0]     cnt;
   logic [COST_W-1:0] mem [N_W][N_J];
   logic              accept;
   // clear outranks a same-cycle handshake so the dropped beat never reaches memory
   assign accept = in_valid & (state == LOAD) & ~clear;
   assign Cost   = mem[W][J];
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= LOAD;
         cnt      <= '0;
         in_ready <= 1'b1;
         Loaded   <= 1'b0;
         for (int r = 0; r < N_W; r++)
            for (int c = 0; c < N_J; c++) mem[r][c] <= '0;
      end else if (clear) begin
         state    <= LOAD;
         cnt      <= '0;
         in_ready <= 1'b1;
         Loaded   <= 1'b0;
      end else if (accept) begin
         mem[cnt[CW-1:JW]][cnt[JW-1:0]] <= in_cost;
         cnt <= cnt + 1'b1;
         if (cnt == CW'(BEATS - 1)) begin
            state    <= FULL;
            in_ready <= 1'b0;
            Loaded   <= 1'b1;
         end
      end
   end
   row_min_acc #(.N_W(N_W), .COST_W(COST_W), .LB_W(LB_W)) u_row_min_acc (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .clear       (clear),
      .wr          (accept),
      .row         (cnt[CW-1:JW]),
      .last        (&cnt[JW-1:0]),
      .cost        (in_cost),
      .lower_bound (LowerBound)
   );
endmodule

// File: tb/tb_jam_cost_loader.sv
// tb_jam_cost_loader: directed load/clear/reset sequences with a LowerBound scoreboard and table model
module tb_jam_cost_loader;
   logic       CLK = 1'b0;
   logic       RST_N;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] in_cost;
   logic       clear;
   logic [2:0] W;
   logic [2:0] J;
   logic [6:0] Cost;
   logic       Loaded;
   logic [9:0] LowerBound;
   int         compared = 0;
   int         mismatched = 0;
   int         sb_lb [$];
   logic [6:0] vals [64];
   logic [6:0] exp_mem [8][8];

   jam_cost_loader dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_cost    (in_cost),
      .clear      (clear),
      .W          (W),
      .J          (J),
      .Cost       (Cost),
      .Loaded     (Loaded),
      .LowerBound (LowerBound)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_lb();
      int sum = 0;
      for (int r = 0; r < 8; r++) begin
         int m = 127;
         for (int c = 0; c < 8; c++) if (int'(vals[r*8+c]) < m) m = int'(vals[r*8+c]);
         sum += m;
      end
      return sum;
   endfunction

   task automatic stream(input int n, input bit gaps, input bit hold_valid);
      for (int i = 0; i < n; i++) begin
         int t = 0;
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            @(negedge CLK);
         end
         in_valid = 1'b1;
         in_cost  = vals[i];
         if (n == 64 && i == 63) begin
            sb_lb.push_back(exp_lb());
            chk("loaded_before_last_beat", 32'(Loaded), 0);
         end
         while (in_ready !== 1'b1 && t < 20) begin
            @(negedge CLK);
            t++;
         end
         if (t == 20) chk("in_ready_timeout", 32'(in_ready), 1);
         exp_mem[i/8][i%8] = vals[i];
         @(negedge CLK);
      end
      in_valid = hold_valid;
   endtask

   task automatic check_full(input string tag);
      chk({tag, "_loaded"}, 32'(Loaded), 1);
      if (sb_lb.size() == 0) begin
         compared++;
         mismatched++;
         $error("FAIL %s_scoreboard_empty observed=0 expected=1", tag);
      end else begin
         chk({tag, "_lower_bound"}, 32'(LowerBound), 32'(sb_lb.pop_front()));
      end
      for (int w = 0; w < 8; w++)
         for (int j = 0; j < 8; j++) begin
            W = 3'(w);
            J = 3'(j);
            #1;
            chk($sformatf("%s_cost_%0d_%0d", tag, w, j), 32'(Cost), 32'(exp_mem[w][j]));
         end
      @(negedge CLK);
   endtask

   task automatic lookup(input string tag, input int w, input int j, input int exp);
      W = 3'(w);
      J = 3'(j);
      #1;
      chk(tag, 32'(Cost), 32'(exp));
   endtask

   task automatic pulse_clear();
      @(negedge CLK);
      clear = 1'b1;
      @(negedge CLK);
      clear = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST_N = 1'b0; in_valid = 1'b0; in_cost = '0; clear = 1'b0; W = '0; J = '0;
      #12;
      chk("reset_in_ready", 32'(in_ready), 1);
      chk("reset_loaded", 32'(Loaded), 0);
      chk("reset_lower_bound", 32'(LowerBound), 0);
      chk("reset_cost", 32'(Cost), 0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < 64; i++) vals[i] = 7'(i);
      stream(64, 1'b0, 1'b0);
      check_full("ramp");
      lookup("ramp_cost_2_5", 2, 5, 21);
      chk("ramp_lower_bound_224", 32'(LowerBound), 224);

      pulse_clear();
      chk("clear_full_loaded", 32'(Loaded), 0);
      chk("clear_full_in_ready", 32'(in_ready), 1);
      chk("clear_full_lower_bound", 32'(LowerBound), 0);

      for (int i = 0; i < 64; i++) vals[i] = 7'd127;
      stream(64, 1'b1, 1'b1);
      check_full("max");
      chk("max_lower_bound_1016", 32'(LowerBound), 1016);
      chk("max_in_ready_held_valid", 32'(in_ready), 0);
      @(negedge CLK);
      chk("max_in_ready_later", 32'(in_ready), 0);
      chk("max_loaded_later", 32'(Loaded), 1);
      in_valid = 1'b0;
      pulse_clear();

      for (int i = 0; i < 64; i++) vals[i] = (i / 8 == 3) ? ((i % 8 == 6) ? 7'd2 : 7'd9) : 7'd50;
      stream(64, 1'b1, 1'b0);
      check_full("row3");
      chk("row3_lower_bound_352", 32'(LowerBound), 352);
      pulse_clear();

      for (int i = 0; i < 64; i++) vals[i] = 7'(i);
      stream(40, 1'b0, 1'b1);
      in_cost = 7'd99;
      clear = 1'b1;
      @(negedge CLK);
      clear = 1'b0;
      in_valid = 1'b0;
      chk("midclear_loaded", 32'(Loaded), 0);
      chk("midclear_lower_bound", 32'(LowerBound), 0);
      for (int i = 0; i < 64; i++) vals[i] = 7'd1;
      stream(64, 1'b0, 1'b0);
      check_full("ones");
      chk("ones_lower_bound_8", 32'(LowerBound), 8);
      lookup("ones_cost_7_7", 7, 7, 1);

      pulse_clear();
      for (int i = 0; i < 64; i++) vals[i] = 7'($urandom_range(0, 127));
      stream(30, 1'b0, 1'b1);
      #2;
      RST_N = 1'b0;
      #1;
      chk("midreset_loaded", 32'(Loaded), 0);
      chk("midreset_in_ready", 32'(in_ready), 1);
      chk("midreset_lower_bound", 32'(LowerBound), 0);
      in_valid = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      for (int i = 0; i < 64; i++) vals[i] = 7'($urandom_range(0, 127));
      vals[0] = 7'd77;
      stream(64, 1'b1, 1'b0);
      check_full("rand");
      lookup("rand_cost_0_0_first_beat", 0, 0, 77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/jam_cost_loader.md
# jam_cost_loader

Upstream feeder for the job-assignment search engine. Accepts the 8×8 worker/job cost matrix as a 64-beat valid/ready stream, stores it in a register file, and serves the search engine's combinational `W`/`J` → `Cost` lookups once the table is complete. While loading, it also accumulates per-worker row minima and their sum, `LowerBound`, which is the admissible bound the search stage uses for pruning and sanity checks.

## Interface
- `N_W`, default 8: workers (rows); power of two.
- `N_J`, default 8: jobs (columns); power of two.
- `COST_W`, default 7: cost entry width.
- `LB_W`, default 10: LowerBound width; must hold N_W·(2^COST_W−1).

Ports:
- `CLK` input 1: single clock, rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `in_valid` input 1: stream beat valid.
- `in_ready` output 1: loader can accept a beat.
- `in_cost` input COST_W: cost entry; row-major order (worker 0 job 0 … worker 7 job 7).
- `clear` input 1: single-cycle request to discard the table and reload.
- `W` input log2(N_W): worker index for lookup.
- `J` input log2(N_J): job index for lookup.
- `Cost` output COST_W: combinational `mem[W][J]`.
- `Loaded` output 1: table complete and lookups valid.
- `LowerBound` output LB_W: sum of row minima; valid while `Loaded`=1.

## Operation
- States: LOAD and FULL. Reset enters LOAD with beat counter `cnt`=0, all memory entries=0, all row minima=all-ones, `LowerBound`=0, `Loaded`=0.
- LOAD: `in_ready`=1. A beat is accepted when `in_valid`&`in_ready`. The beat writes `mem[cnt[5:3]][cnt[2:0]]`, updates `rowmin[cnt[5:3]] = min(rowmin, in_cost)`, and increments `cnt` (6-bit).
- Row completion: on an accepted beat with `cnt[2:0]`=7, add `min(rowmin[row], in_cost)` (which includes the current beat) to the LowerBound accumulator.
- On the 64th accepted beat (`cnt`=63): next state is FULL and `cnt` wraps to 0.
- FULL: `in_ready`=0, `Loaded`=1, memory frozen. `in_valid` is ignored.
- `clear`, in any state, wins over a same-cycle handshake; that beat is dropped, not written. Next cycle: LOAD, `cnt`=0, `Loaded`=0, `LowerBound`=0, row minima=all-ones. Memory is not cleared; every entry is overwritten by the reload.
- `Cost` is a pure mux of the stored array and is valid for any `W`/`J` in any state. Contents are defined only while `Loaded`=1.
- Width rule: the LowerBound adder is LB_W wide, zero-extending COST_W. There is no overflow, by parameter constraint.

## Timing
- `in_ready` is a registered function of state only and does not depend on `in_valid`.
- `Loaded` and the final `LowerBound` both rise on the clock edge that accepts beat 64. There is no extra latency.
- `Cost` follows `W`/`J` within the same cycle, which the search stage requires for its per-cycle accumulation.
- `clear` takes effect on the next edge. `Loaded` drops one cycle after `clear` is sampled.
- Async reset mid-load drops all progress immediately. After reset release, the first accepted beat is entry (0,0).
- Reset values: `in_ready`=1, `Loaded`=0, `LowerBound`=0, `Cost`=0.

## Structure
- Shared package holds:
  - N_W, N_J, COST_W, LB_W;
  - the state enum {LOAD, FULL};
  - TABLE_BEATS = N_W·N_J.
- The search stage reuses the same constants from this package.
- One sub-module, `row_min_acc`, owns the per-row running minimum and the LowerBound accumulation. Its inputs are the write strobe, row, last-in-row flag, and cost.
- The top level holds the FSM, counter, memory and read mux.

## Test plan
- Stream values 0..63 with `in_valid` held high. Then:
  - `Loaded` rises after 64 accepts;
  - `W`=2,`J`=5 gives `Cost`=21;
  - `LowerBound`=0+8+16+…+56=224.
- Stream all entries = 127 with random `in_valid` gaps. Expect `LowerBound`=1016, and `in_ready` low while `Loaded`=1 despite continued `in_valid`.
- Make row 3 all 9 except (3,6)=2, with all other entries 50. Expect `LowerBound`=7·50+2=352.
- Assert `clear` on the same cycle as beat 40, then stream 64 beats of value 1. Expect `Loaded` after exactly 64 new accepts, `LowerBound`=8, and `Cost`(7,7)=1.
- Assert `RST_N` low at beat 30, then release and stream a full table. Expect `Loaded` only after 64 post-reset accepts, and entry (0,0) equal to the first post-reset beat.
- Load a table, then issue `clear` in FULL. Expect `Loaded`=0, `in_ready`=1, `LowerBound`=0 on the next cycle.
